// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and the {pc, instr} fetch entry
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_WIDTH = 32;
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of entry_t; ports clk, rst, push, pop, flush (wins over push), din, dout (head), count, empty, full
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  entry_t                       din,
  output entry_t                       dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  always_comb begin
    dout  = mem[rd];
    empty = count == '0;
    full  = count == CW'(DEPTH);
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: ROM fetch initiator; ports clk, rst, mem_addr/mem_q (1-cycle ROM), redirect_valid/redirect_pc, out_valid/out_ready/out_pc/out_instr
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              ADDRESS_WIDTH = 14,
  parameter int              DATA_WIDTH    = 32,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_q,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr
);
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;
  logic [XLEN-1:0] pc, inflight_pc, issue_pc;
  logic inflight_valid, issue, pop, push, empty, full;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  entry_t head;
  always_comb begin
    issue_pc  = redirect_valid ? (redirect_pc & ~XLEN'(3)) : pc;
    mem_addr  = rst ? RESET_PC[ADDRESS_WIDTH+1:2] : issue_pc[ADDRESS_WIDTH+1:2];
    out_valid = !empty;
    pop       = out_valid & out_ready;
    push      = inflight_valid & !redirect_valid;
    // credit: words buffered plus the one in flight must leave room for this issue
    issue     = redirect_valid | ((int'(count) + int'(inflight_valid) - int'(pop)) < FIFO_DEPTH);
    out_pc    = out_valid ? head.pc : '0;
    out_instr = out_valid ? head.instr : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= issue_pc;
        pc          <= issue_pc + XLEN'(4);
      end
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({inflight_pc, mem_q}),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(full && inflight_valid));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed checks of fetch_unit (ADDRESS_WIDTH 14 and 4) against a queue model
module tb_fetch_unit;
  logic clk, rst, out_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [13:0] mem_addr;
  logic [3:0] mem_addr4;
  logic [31:0] mem_q, mem_q4, out_pc, out_pc4, out_instr, out_instr4;
  logic out_valid, out_valid4;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  bit pipe_v = 0;
  logic [31:0] pipe_pc = 0, nxt = 0;

  fetch_unit #(.ADDRESS_WIDTH(14)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_q(mem_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );
  fetch_unit #(.ADDRESS_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr4), .mem_q(mem_q4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4), .out_instr(out_instr4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_q  <= 32'h1000_0000 + 32'(mem_addr);
    mem_q4 <= 32'h1000_0000 + 32'(mem_addr4);
  end

  function automatic logic [31:0] rom(input logic [31:0] pc, input int aw);
    return 32'h1000_0000 + ((pc >> 2) & ((32'd1 << aw) - 32'd1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words emerge in PC order; at most FIFO_DEPTH words buffered or in flight.
  initial begin
    int occ;
    bit pop;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        pipe_v = 0;
        nxt = 0;
      end else begin
        pop = q.size() > 0 && out_ready;
        occ = q.size() + int'(pipe_v) - int'(pop);
        if (pop) void'(q.pop_front());
        if (redirect_valid) begin
          q.delete();
          pipe_v = 1;
          pipe_pc = redirect_pc & ~32'd3;
          nxt = pipe_pc + 32'd4;
        end else begin
          if (pipe_v) q.push_back(pipe_pc);
          pipe_v = occ < 2;
          if (pipe_v) begin
            pipe_pc = nxt;
            nxt = nxt + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] h, ia;
    bit v;
    forever begin
      @(negedge clk);
      if (!rst) begin
        v = q.size() > 0;
        h = v ? q[0] : 32'd0;
        ia = redirect_valid ? (redirect_pc & ~32'd3) : nxt;
        chk("valid", 32'(out_valid), 32'(v));
        chk("valid4", 32'(out_valid4), 32'(v));
        chk("pc", out_pc, h);
        chk("pc4", out_pc4, h);
        chk("instr", out_instr, v ? rom(h, 14) : 32'd0);
        chk("instr4", out_instr4, v ? rom(h, 4) : 32'd0);
        chk("addr", 32'(mem_addr), 32'(ia[15:2]));
        chk("addr4", 32'(mem_addr4), 32'(ia[5:2]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1;
    redirect_pc = target;
    cyc();
    redirect_valid = 0;
  endtask

  initial begin
    int r;
    rst = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
    repeat (3) cyc();
    rst = 0;
    @(negedge clk) chk("lit_rel_valid", 32'(out_valid), 0);
    cyc();
    @(negedge clk) chk("lit_lat_valid", 32'(out_valid), 0);
    cyc();
    out_ready = 0;
    @(negedge clk);
    chk("lit_first_valid", 32'(out_valid), 1);
    chk("lit_first_pc", out_pc, 32'h0);
    chk("lit_first_instr", out_instr, 32'h1000_0000);
    repeat (5) begin
      cyc();
      @(negedge clk) chk("lit_bp_hold", out_pc, 32'h0);
    end
    out_ready = 1;
    cyc();
    @(negedge clk) chk("lit_bp_pc4", out_pc, 32'h4);
    cyc();
    @(negedge clk) chk("lit_bp_pc8", out_pc, 32'h8);
    repeat (3) cyc();
    redirect(32'h100);
    @(negedge clk) chk("lit_rd_flush", 32'(out_valid), 0);
    cyc();
    @(negedge clk);
    chk("lit_rd_pc", out_pc, 32'h100);
    chk("lit_rd_instr", out_instr, 32'h1000_0040);
    cyc();
    @(negedge clk);
    chk("lit_rd_pc2", out_pc, 32'h104);
    chk("lit_rd_instr2", out_instr, 32'h1000_0041);
    cyc();
    redirect(32'h103);
    cyc();
    @(negedge clk) chk("lit_unaligned", out_pc, 32'h100);
    cyc();
    redirect_valid = 1;
    redirect_pc = 32'h200;
    cyc();
    redirect(32'h300);
    @(negedge clk) chk("lit_b2b_flush", 32'(out_valid), 0);
    cyc();
    @(negedge clk) chk("lit_b2b_pc", out_pc, 32'h300);
    cyc();
    redirect(32'h3C);
    cyc();
    @(negedge clk);
    chk("lit_wrap_pc", out_pc4, 32'h3C);
    chk("lit_wrap_instr", out_instr4, 32'h1000_000F);
    cyc();
    @(negedge clk);
    chk("lit_wrap_pc2", out_pc4, 32'h40);
    chk("lit_wrap_instr2", out_instr4, 32'h1000_0000);
    chk("lit_nowrap_instr2", out_instr, 32'h1000_0010);
    repeat (3) cyc();
    #1 rst = 1;
    #1;
    chk("lit_async_valid", 32'(out_valid), 0);
    chk("lit_async_valid4", 32'(out_valid4), 0);
    chk("lit_async_pc", out_pc, 32'h0);
    repeat (2) cyc();
    rst = 0;
    @(negedge clk) chk("lit_rs_valid0", 32'(out_valid), 0);
    cyc();
    @(negedge clk) chk("lit_rs_valid1", 32'(out_valid), 0);
    cyc();
    @(negedge clk);
    chk("lit_rs_valid2", 32'(out_valid), 1);
    chk("lit_rs_pc", out_pc, 32'h0);
    repeat (3000) begin
      cyc();
      out_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 19) == 0;
      r = int'($urandom_range(0, 3));
      redirect_pc = (r == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
    end
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
